// File: rtl/vcve2_vrf_mem.sv
// ---------------------------------------------------------------------------
// vcve2_vrf_mem
//   Memory-side responder for the vector register file data bus. All vector
//   registers live in one single-port array of 32-bit words. Requests are
//   granted in the same cycle (no back-pressure). Every granted request gets
//   exactly one response in the following cycle.
//
//   Optional feature macro: VCVE2_VRF_MEM_CNT_EN
//     defined   : saturating read / write / error counters on *_cnt_o
//     undefined : counter outputs tied to 0, no counter flops
//
// Ports
//   clk_i, rst_i     clock, synchronous active-high reset
//   data_req_i       request valid
//   data_gnt_o       request accepted (combinational, req & ~rst)
//   data_we_i        1 = write, 0 = read
//   data_be_i        byte enables for writes
//   data_addr_i      byte address
//   data_wdata_i     write data
//   data_rvalid_o    response valid, one cycle after grant
//   data_err_o       response error, qualified by data_rvalid_o
//   data_pmp_err_o   constant 0
//   data_rdata_o     read data, qualified by data_rvalid_o
//   rd_cnt_o         accepted (non-errored) read count
//   wr_cnt_o         accepted (non-errored) write count
//   err_cnt_o        errored access count
// ---------------------------------------------------------------------------

`ifdef VCVE2_VRF_MEM_CNT_EN
// Saturating 32-bit event counter.
module vcve2_vrf_mem_sat_cnt (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        inc_i,
    output logic [31:0] cnt_o
);
    logic [31:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) cnt_q <= 32'd0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule
`endif

module vcve2_vrf_mem #(
    parameter int unsigned VLEN          = 128,
    parameter int unsigned NUM_VREGS     = 32,
    parameter logic [31:0] VRF_BASE_ADDR = 32'h0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_req_i,
    output logic        data_gnt_o,
    output logic        data_rvalid_o,
    output logic        data_err_o,
    output logic        data_pmp_err_o,
    input  logic        data_we_i,
    input  logic [3:0]  data_be_i,
    input  logic [31:0] data_addr_i,
    input  logic [31:0] data_wdata_i,
    output logic [31:0] data_rdata_o,
    output logic [31:0] rd_cnt_o,
    output logic [31:0] wr_cnt_o,
    output logic [31:0] err_cnt_o
);
    localparam int unsigned NUM_WORDS = NUM_VREGS * VLEN / 32;
    localparam int unsigned IDX_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int unsigned NUM_BYTES = 4;

    // ---------------------------------------------------------------------
    // Storage: single-port word array with per-byte write enables. Not reset.
    // ---------------------------------------------------------------------
    logic [31:0] mem_q [NUM_WORDS];

    // ---------------------------------------------------------------------
    // Request side
    // ---------------------------------------------------------------------
    logic              gnt;
    logic [31:0]       word_off;
    logic [IDX_W-1:0]  idx;
    logic              misaligned;
    logic              below_base;
    logic              out_of_range;
    logic              acc_err;
    logic              acc_rd;
    logic              acc_wr;

    // Zero-wait grant; the initiator has no stall path.
    assign gnt        = data_req_i & ~rst_i;
    assign data_gnt_o = gnt;

    // Offset wraps modulo 2^32; below_base catches the wrapped case so a
    // huge wrapped offset can never alias into the array.
    assign word_off     = (data_addr_i - VRF_BASE_ADDR) >> 2;
    assign idx          = word_off[IDX_W-1:0];
    assign misaligned   = |data_addr_i[1:0];
    assign below_base   = data_addr_i < VRF_BASE_ADDR;
    assign out_of_range = word_off >= 32'(NUM_WORDS);
    assign acc_err      = misaligned | below_base | out_of_range;

    assign acc_rd = gnt & ~data_we_i & ~acc_err;
    assign acc_wr = gnt &  data_we_i & ~acc_err;

    // Write port. Only in-range, granted writes touch the array, so a write
    // during reset or an errored write leaves contents intact.
    always_ff @(posedge clk_i) begin
        if (acc_wr) begin
            for (int k = 0; k < NUM_BYTES; k++) begin
                if (data_be_i[k]) mem_q[idx][8*k +: 8] <= data_wdata_i[8*k +: 8];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Response register: one-cycle fixed latency. rdata/err hold their last
    // value when no response is being returned.
    // ---------------------------------------------------------------------
    logic        rvalid_q, rvalid_d;
    logic        err_q,    err_d;
    logic [31:0] rdata_q,  rdata_d;

    always_comb begin
        rvalid_d = gnt;
        err_d    = err_q;
        rdata_d  = rdata_q;
        if (gnt) begin
            err_d   = acc_err;
            // Errors and write acks return zero data; only a clean read
            // drives the array contents back.
            rdata_d = acc_rd ? mem_q[idx] : 32'd0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= 32'd0;
        end else begin
            rvalid_q <= rvalid_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
        end
    end

    assign data_rvalid_o  = rvalid_q;
    assign data_err_o     = err_q;
    assign data_rdata_o   = rdata_q;
    assign data_pmp_err_o = 1'b0;

    // ---------------------------------------------------------------------
    // Access counters: bump on the grant cycle; an errored access counts
    // only as an error, never as a read or write.
    // ---------------------------------------------------------------------
`ifdef VCVE2_VRF_MEM_CNT_EN
    logic [2:0]       cnt_inc;
    logic [2:0][31:0] cnt_val;

    assign cnt_inc = {gnt & acc_err, acc_wr, acc_rd};

    for (genvar c = 0; c < 3; c++) begin : g_cnt
        vcve2_vrf_mem_sat_cnt u_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc_i (cnt_inc[c]),
            .cnt_o (cnt_val[c])
        );
    end

    assign rd_cnt_o  = cnt_val[0];
    assign wr_cnt_o  = cnt_val[1];
    assign err_cnt_o = cnt_val[2];
`else
    assign rd_cnt_o  = 32'd0;
    assign wr_cnt_o  = 32'd0;
    assign err_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_vcve2_vrf_mem.sv
// Self-checking bench for vcve2_vrf_mem: word-level reference model, a
// per-cycle compare process, directed literal checks and a random phase.
module tb_vcve2_vrf_mem;
    localparam int unsigned NW   = 128;
    localparam logic [31:0] BASE = 32'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic        req, we;
    logic [3:0]  be;
    logic [31:0] addr, wdata;
    logic        gnt, rvalid, err, pmp_err;
    logic [31:0] rdata, rd_cnt, wr_cnt, err_cnt;

    always #5 clk = ~clk;

    vcve2_vrf_mem dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .data_req_i     (req),
        .data_gnt_o     (gnt),
        .data_rvalid_o  (rvalid),
        .data_err_o     (err),
        .data_pmp_err_o (pmp_err),
        .data_we_i      (we),
        .data_be_i      (be),
        .data_addr_i    (addr),
        .data_wdata_i   (wdata),
        .data_rdata_o   (rdata),
        .rd_cnt_o       (rd_cnt),
        .wr_cnt_o       (wr_cnt),
        .err_cnt_o      (err_cnt)
    );

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_mem [NW];
    logic        m_rvalid, m_err;
    logic [31:0] m_rdata;
    logic [31:0] m_rd, m_wr, m_ec;

    function automatic bit addr_bad(input logic [31:0] a);
        longint unsigned la = a;
        longint unsigned lb = BASE;
        if (la % 4 != 0) return 1'b1;
        if (la < lb) return 1'b1;
        return ((la - lb) / 4) >= NW;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 + 32'(i * 7);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_rvalid <= 1'b0;
            m_err    <= 1'b0;
            m_rdata  <= 32'd0;
            m_rd <= 32'd0; m_wr <= 32'd0; m_ec <= 32'd0;
        end else if (req) begin
            m_rvalid <= 1'b1;
            if (addr_bad(addr)) begin
                m_err   <= 1'b1;
                m_rdata <= 32'd0;
                m_ec    <= sat_inc(m_ec);
            end else if (we) begin
                m_err   <= 1'b0;
                m_rdata <= 32'd0;
                m_wr    <= sat_inc(m_wr);
                for (int k = 0; k < 4; k++)
                    if (be[k]) m_mem[(addr - BASE) / 4][8*k +: 8] <= wdata[8*k +: 8];
            end else begin
                m_err   <= 1'b0;
                m_rdata <= m_mem[(addr - BASE) / 4];
                m_rd    <= sat_inc(m_rd);
            end
        end else begin
            m_rvalid <= 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            chk("gnt",     {31'd0, gnt},     {31'd0, req & ~rst});
            chk("rvalid",  {31'd0, rvalid},  {31'd0, m_rvalid});
            chk("err",     {31'd0, err},     {31'd0, m_err});
            chk("rdata",   rdata,            m_rdata);
            chk("pmp_err", {31'd0, pmp_err}, 32'd0);
`ifdef VCVE2_VRF_MEM_CNT_EN
            chk("rd_cnt",  rd_cnt,  m_rd);
            chk("wr_cnt",  wr_cnt,  m_wr);
            chk("err_cnt", err_cnt, m_ec);
`else
            chk("rd_cnt",  rd_cnt,  32'd0);
            chk("wr_cnt",  wr_cnt,  32'd0);
            chk("err_cnt", err_cnt, 32'd0);
`endif
        end
    end

    // One bus cycle; returns just after the edge, when the response to this
    // request is visible on the outputs.
    task automatic drive(input logic r, input logic q, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d);
        rst = r; req = q; we = w; be = b; addr = a; wdata = d;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] EXP_RD8 =
`ifdef VCVE2_VRF_MEM_CNT_EN
        32'd8;
`else
        32'd0;
`endif

    initial begin
        rst = 1'b1; req = 1'b1; we = 1'b0; be = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset held two cycles with a pending request.
        drive(1, 1, 0, 4'h0, 32'h0, 32'h0);
        drive(1, 1, 0, 4'h0, 32'h0, 32'h0);
        chk("rst_gnt",    {31'd0, gnt},    32'd0);
        chk("rst_rvalid", {31'd0, rvalid}, 32'd0);
        chk("rst_rdata",  rdata,           32'd0);
        chk("rst_rdcnt",  rd_cnt | wr_cnt | err_cnt, 32'd0);
        rst = 1'b0; req = 1'b0;
        chk_en = 1'b1;

        // Fill the array so the model knows every word.
        for (int i = 0; i < int'(NW); i++) drive(0, 1, 1, 4'hF, BASE + 32'(4*i), pat(i));

        // Write then read-after-write.
        drive(0, 1, 1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        chk("wr_rvalid", {31'd0, rvalid}, 32'd1);
        chk("wr_rdata",  rdata,           32'd0);
        drive(0, 1, 0, 4'h0, 32'h10, 32'h0);
        chk("raw_rvalid", {31'd0, rvalid}, 32'd1);
        chk("raw_rdata",  rdata,           32'hDEAD_BEEF);
        chk("raw_err",    {31'd0, err},    32'd0);

        // Byte enables.
        drive(0, 1, 1, 4'hF,    32'h20, 32'h1122_3344);
        drive(0, 1, 1, 4'b0101, 32'h20, 32'hAABB_CCDD);
        drive(0, 1, 1, 4'b0000, 32'h20, 32'hFFFF_FFFF);
        chk("be0_rvalid", {31'd0, rvalid}, 32'd1);
        drive(0, 1, 0, 4'h0, 32'h20, 32'h0);
        chk("be_rdata", rdata, 32'h11BB_33DD);

        // Error responses; the write to 0x200 must not alias onto word 0.
        drive(0, 1, 0, 4'h0, 32'h202, 32'h0);
        chk("mis_err",   {31'd0, err}, 32'd1);
        chk("mis_rdata", rdata,        32'd0);
        drive(0, 1, 0, 4'h0, 32'h200, 32'h0);
        chk("oor_err",   {31'd0, err}, 32'd1);
        drive(0, 1, 1, 4'hF, 32'h200, 32'h1234_5678);
        chk("oorw_err",  {31'd0, err}, 32'd1);
        drive(0, 1, 0, 4'h0, 32'h000, 32'h0);
        chk("oorw_noalias", rdata, pat(0));
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk("idle_hold", rdata, pat(0));

        // Streaming reads after a fresh reset.
        drive(1, 0, 0, 4'h0, 32'h0, 32'h0);
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 4'h0, 32'(4*i), 32'h0);
            chk("stream_rvalid", {31'd0, rvalid}, 32'd1);
        end
        chk("stream_w4", rdata, pat(7));
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        chk("stream_rdcnt", rd_cnt, EXP_RD8);

        // Reset during the 3rd (and 4th) write of a burst.
        drive(0, 1, 1, 4'hF, 32'h40, 32'hA000_0001);
        chk("burst_rv1", {31'd0, rvalid}, 32'd1);
        drive(0, 1, 1, 4'hF, 32'h44, 32'hA000_0002);
        chk("burst_rv2", {31'd0, rvalid}, 32'd1);
        drive(1, 1, 1, 4'hF, 32'h48, 32'hA000_0003);
        chk("burst_rv3", {31'd0, rvalid}, 32'd0);
        drive(1, 1, 1, 4'hF, 32'h4C, 32'hA000_0004);
        chk("burst_rv4", {31'd0, rvalid}, 32'd0);
        chk("burst_cnt", rd_cnt | wr_cnt | err_cnt, 32'd0);
        drive(0, 1, 0, 4'h0, 32'h48, 32'h0);
        chk("burst_w3", rdata, pat(18));
        drive(0, 1, 0, 4'h0, 32'h4C, 32'h0);
        chk("burst_w4", rdata, pat(19));
        drive(0, 1, 0, 4'h0, 32'h44, 32'h0);
        chk("burst_w2", rdata, 32'hA000_0002);

        // Random traffic.
        for (int n = 0; n < 1500; n++) begin
            logic [31:0] a;
            int sel = $urandom_range(0, 9);
            if (sel < 7)       a = BASE + 32'(4 * $urandom_range(0, NW - 1));
            else if (sel == 7) a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(1, 3));
            else if (sel == 8) a = BASE + 32'(4 * NW) + 32'(4 * $urandom_range(0, 255));
            else               a = $urandom;
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                  4'($urandom_range(0, 15)), a, $urandom);
        end
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);
        drive(0, 0, 0, 4'h0, 32'h0, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
